// File: rtl/bme280_sample_sequencer.sv
// BME280 raw sample sequencer: walks eight register reads through an I2C
// wrapper and publishes pressure/temperature/humidity raw words atomically.
module bme280_sample_sequencer #(
  parameter int WAIT_CYCLES = 150,
  parameter int BASE_SEL    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  output logic        en,
  output logic [3:0]  register_selector,
  input  logic [7:0]  data,
  output logic        busy,
  output logic        sample_valid,
  output logic [19:0] press_raw,
  output logic [19:0] temp_raw,
  output logic [15:0] hum_raw
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [3:0] BASE = 4'(BASE_SEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   pst_q, pst_d;
  logic [19:0]   tst_q, tst_d;
  logic [7:0]    hst_q, hst_d;
  logic [19:0]   press_q, press_d;
  logic [19:0]   temp_q, temp_d;
  logic [15:0]   hum_q, hum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pst_q   <= '0;
      tst_q   <= '0;
      hst_q   <= '0;
      press_q <= '0;
      temp_q  <= '0;
      hum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pst_q   <= pst_d;
      tst_q   <= tst_d;
      hst_q   <= hst_d;
      press_q <= press_d;
      temp_q  <= temp_d;
      hum_q   <= hum_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pst_d        = pst_q;
    tst_d        = tst_q;
    hst_d        = hst_q;
    press_d      = press_q;
    temp_d       = temp_q;
    hum_d        = hum_q;
    en           = 1'b0;
    sample_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        en      = 1'b1;
        cnt_d   = '0;
        state_d = (WAIT_CYCLES == 0) ? S_CAP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAST) state_d = S_CAP;
        else cnt_d = cnt_q + CW'(1);
      end
      S_CAP: begin
        // Only the upper nibble of each xlsb byte carries data.
        case (idx_q)
          3'd0:    pst_d[19:12] = data;
          3'd1:    pst_d[11:4]  = data;
          3'd2:    pst_d[3:0]   = data[7:4];
          3'd3:    tst_d[19:12] = data;
          3'd4:    tst_d[11:4]  = data;
          3'd5:    tst_d[3:0]   = data[7:4];
          3'd6:    hst_d        = data;
          default: ;
        endcase
        if (idx_q == 3'd7) begin
          press_d = pst_q;
          temp_d  = tst_q;
          hum_d   = {hst_q, data};
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        sample_valid = 1'b1;
        if (continuous || start) begin
          idx_d   = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign register_selector = BASE + {1'b0, idx_q};
  assign busy              = (state_q != S_IDLE);
  assign press_raw         = press_q;
  assign temp_raw          = temp_q;
  assign hum_raw           = hum_q;

endmodule

// File: tb/tb_bme280_sample_sequencer.sv
// Scoreboard bench for bme280_sample_sequencer: stimulus queues expected
// en strobes and samples, monitors pop and compare them.
module tb_bme280_sample_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
  } en_exp_t;

  typedef struct {
    int          cyc;
    logic [19:0] p;
    logic [19:0] t;
    logic [15:0] h;
  } sv_exp_t;

  logic clk = 1'b0;
  logic rst, start, continuous, start_b;
  logic        en_a, busy_a, sv_a;
  logic [3:0]  sel_a;
  logic [7:0]  data_a;
  logic [19:0] p_a, t_a;
  logic [15:0] h_a;
  logic        en_b, busy_b, sv_b;
  logic [3:0]  sel_b;
  logic [7:0]  data_b;
  logic [19:0] p_b, t_b;
  logic [15:0] h_b;

  logic [7:0] mem [16];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  en_exp_t qa_en[$];
  sv_exp_t qa_sv[$];
  en_exp_t qb_en[$];
  sv_exp_t qb_sv[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_a = mem[sel_a];
  assign data_b = 8'h10 + {4'h0, sel_b};

  bme280_sample_sequencer #(.WAIT_CYCLES(4), .BASE_SEL(0)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .en(en_a), .register_selector(sel_a), .data(data_a),
    .busy(busy_a), .sample_valid(sv_a),
    .press_raw(p_a), .temp_raw(t_a), .hum_raw(h_a)
  );

  bme280_sample_sequencer #(.WAIT_CYCLES(0), .BASE_SEL(12)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .continuous(1'b0),
    .en(en_b), .register_selector(sel_b), .data(data_b),
    .busy(busy_b), .sample_valid(sv_b),
    .press_raw(p_b), .temp_raw(t_b), .hum_raw(h_b)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got pulse expected none at cycle %0d", name, cyc);
  endtask

  always @(posedge clk) begin : mon_a
    en_exp_t e;
    sv_exp_t s;
    #2;
    if (en_a) begin
      if (qa_en.size() == 0) unexpected("en_a");
      else begin
        e = qa_en.pop_front();
        chk("en_a cycle", cyc, e.cyc);
        chk("en_a sel", {28'h0, sel_a}, {28'h0, e.sel});
      end
    end
    if (sv_a) begin
      if (qa_sv.size() == 0) unexpected("sv_a");
      else begin
        s = qa_sv.pop_front();
        chk("sv_a cycle", cyc, s.cyc);
        chk("press_a", {12'h0, p_a}, {12'h0, s.p});
        chk("temp_a", {12'h0, t_a}, {12'h0, s.t});
        chk("hum_a", {16'h0, h_a}, {16'h0, s.h});
      end
    end
  end

  always @(posedge clk) begin : mon_b
    en_exp_t e;
    sv_exp_t s;
    #2;
    if (en_b) begin
      if (qb_en.size() == 0) unexpected("en_b");
      else begin
        e = qb_en.pop_front();
        chk("en_b cycle", cyc, e.cyc);
        chk("en_b sel", {28'h0, sel_b}, {28'h0, e.sel});
      end
    end
    if (sv_b) begin
      if (qb_sv.size() == 0) unexpected("sv_b");
      else begin
        s = qb_sv.pop_front();
        chk("sv_b cycle", cyc, s.cyc);
        chk("press_b", {12'h0, p_b}, {12'h0, s.p});
        chk("temp_b", {12'h0, t_b}, {12'h0, s.t});
        chk("hum_b", {16'h0, h_b}, {16'h0, s.h});
      end
    end
  end

  task automatic push_a(input int k, input logic [19:0] p,
                        input logic [19:0] t, input logic [15:0] h);
    en_exp_t e;
    sv_exp_t s;
    for (int i = 0; i < 8; i++) begin
      e.cyc = k + 6 * i;
      e.sel = 4'(i);
      qa_en.push_back(e);
    end
    s.cyc = k + 48;
    s.p = p;
    s.t = t;
    s.h = h;
    qa_sv.push_back(s);
  endtask

  task automatic start_a(output int k, input logic [19:0] p,
                         input logic [19:0] t, input logic [15:0] h);
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    push_a(k, p, t, h);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((qa_en.size() + qa_sv.size() + qb_en.size() + qb_sv.size()) != 0
           && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((qa_en.size() + qa_sv.size() + qb_en.size() + qb_sv.size()) != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 after %0d cycles",
               qa_en.size() + qa_sv.size() + qb_en.size() + qb_sv.size(), maxc);
      qa_en.delete();
      qa_sv.delete();
      qb_en.delete();
      qb_sv.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    en_exp_t e;
    sv_exp_t s;
    rst = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    continuous = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    repeat (3) @(negedge clk);
    chk("rst busy", {31'h0, busy_a}, 32'h0);
    chk("rst en", {31'h0, en_a}, 32'h0);
    chk("rst sv", {31'h0, sv_a}, 32'h0);
    chk("rst sel_a", {28'h0, sel_a}, 32'h0);
    chk("rst sel_b", {28'h0, sel_b}, 32'hC);
    chk("rst press", {12'h0, p_a}, 32'h0);
    chk("rst hum", {16'h0, h_a}, 32'h0);
    rst = 1'b0;

    start_a(k, 20'h10111, 20'h13141, 16'h1617);
    drain(200);
    repeat (2) @(negedge clk);
    chk("idle busy", {31'h0, busy_a}, 32'h0);
    chk("hold press", {12'h0, p_a}, 32'h10111);

    mem[2] = 8'hFF;
    mem[5] = 8'h0F;
    start_a(k, 20'h1011F, 20'h13140, 16'h1617);
    drain(200);
    mem[2] = 8'h12;
    mem[5] = 8'h15;

    start_a(k, 20'h10111, 20'h13141, 16'h1617);
    wait_cyc(k + 20);
    chk("in wait busy", {31'h0, busy_a}, 32'h1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(200);
    repeat (2) @(negedge clk);
    chk("ign start busy", {31'h0, busy_a}, 32'h0);

    continuous = 1'b1;
    start_a(k, 20'h10111, 20'h13141, 16'h1617);
    push_a(k + 49, 20'h10111, 20'h13141, 16'h1617);
    wait_cyc(k + 49 + 20);
    continuous = 1'b0;
    drain(300);
    repeat (2) @(negedge clk);
    chk("cont end busy", {31'h0, busy_a}, 32'h0);

    rst = 1'b1;
    start = 1'b1;
    continuous = 1'b1;
    @(negedge clk);
    chk("rst prio busy", {31'h0, busy_a}, 32'h0);
    chk("rst prio en", {31'h0, en_a}, 32'h0);
    rst = 1'b0;
    start = 1'b0;
    continuous = 1'b0;

    mem[0] = 8'hA5;
    start_a(k, 20'hA5111, 20'h13141, 16'h1617);
    wait_cyc(k + 32);
    rst = 1'b1;
    qa_en.delete();
    qa_sv.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort en", {31'h0, en_a}, 32'h0);
    chk("abort busy", {31'h0, busy_a}, 32'h0);
    chk("abort press", {12'h0, p_a}, 32'h0);
    chk("abort temp", {12'h0, t_a}, 32'h0);
    chk("abort hum", {16'h0, h_a}, 32'h0);
    repeat (3) @(negedge clk);
    start_a(k, 20'hA5111, 20'h13141, 16'h1617);
    drain(200);
    mem[0] = 8'h10;

    @(negedge clk);
    start_b = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      e.cyc = k + 2 * i;
      e.sel = 4'(12 + i);
      qb_en.push_back(e);
    end
    s.cyc = k + 16;
    s.p = 20'h1C1D1;
    s.t = 20'h1F101;
    s.h = 16'h1213;
    qb_sv.push_back(s);
    @(negedge clk);
    start_b = 1'b0;
    drain(100);
    repeat (2) @(negedge clk);
    chk("b idle busy", {31'h0, busy_b}, 32'h0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bme280_sample_sequencer.md
BME280_SAMPLE_SEQUENCER -- requirements
Module: bme280_sample_sequencer

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 150, which is the number of idle cycles between an en pulse and capture of data (3 us at a 50 MHz clk).
REQ-002 The block SHALL have parameter BASE_SEL, default 0, which is the register_selector code of the first raw byte; the 8 raw bytes occupy codes BASE_SEL..BASE_SEL+7.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: requests one full 8-byte sample.
REQ-006 The block SHALL have port continuous, input, 1 bit: when 1, a new sample starts automatically after each completed sample.
REQ-007 The block SHALL have port en, output, 1 bit: one-cycle read strobe to the downstream I2C wrapper.
REQ-008 The block SHALL have port register_selector, output, 4 bits: register code to the wrapper.
REQ-009 The block SHALL have port data, input, 8 bits: read byte from the wrapper.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port sample_valid, output, 1 bit: one-cycle pulse when the raw outputs update.
REQ-012 The block SHALL have port press_raw, output, 20 bits: raw pressure.
REQ-013 The block SHALL have port temp_raw, output, 20 bits: raw temperature.
REQ-014 The block SHALL have port hum_raw, output, 16 bits: raw humidity.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, CAPTURE and DONE, plus a 3-bit byte index idx and a wait counter of width clog2(WAIT_CYCLES+1).
REQ-016 In IDLE, start=1 at a clock edge SHALL load idx=0 and move the FSM to REQ; start=0 SHALL keep the FSM in IDLE.
REQ-017 In REQ, en SHALL be 1 for exactly that one cycle, and the next state SHALL be WAIT with the counter cleared.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES cycles and then move to CAPTURE; WAIT_CYCLES=0 SHALL go directly from REQ to CAPTURE.
REQ-019 In CAPTURE, data SHALL be latched into internal byte buffer[idx]; if idx<7, idx SHALL increment and the FSM SHALL go to REQ; if idx=7, the FSM SHALL go to DONE.
REQ-020 register_selector SHALL equal BASE_SEL+idx (mod 16) from REQ through CAPTURE of each byte, and SHALL be held stable while en=1 and until capture.
REQ-021 Byte order by idx SHALL be: 0 press_msb, 1 press_lsb, 2 press_xlsb, 3 temp_msb, 4 temp_lsb, 5 temp_xlsb, 6 hum_msb, 7 hum_lsb.
REQ-022 In DONE, the three raw outputs SHALL update together and sample_valid SHALL be 1 for that cycle only, with press_raw={b0,b1,b2[7:4]}, temp_raw={b3,b4,b5[7:4]} and hum_raw={b6,b7}.
REQ-023 Raw outputs SHALL change only in DONE and SHALL hold otherwise, so a partial sample is never visible.
REQ-024 From DONE, the next state SHALL be REQ with idx=0 if continuous=1 or start=1, and IDLE otherwise.
REQ-025 start SHALL be ignored in REQ, WAIT and CAPTURE, with no queuing.
REQ-026 Dropping continuous to 0 mid-sample SHALL let the current sample complete and then return to IDLE.
REQ-027 Latency: with start sampled at edge k, en SHALL pulse in cycle k+1 and then every WAIT_CYCLES+2 cycles, 8 pulses in total; sample_valid SHALL occur in cycle k+1+8*(WAIT_CYCLES+2).

Reset
REQ-028 While rst=1 at a clock edge, state SHALL be IDLE, idx and counter 0, en 0, busy 0, sample_valid 0, register_selector BASE_SEL, raw outputs and buffer 0.
REQ-029 rst mid-sample SHALL abort the sample with no sample_valid, and the raw outputs SHALL read 0 after the reset edge.
REQ-030 rst SHALL take priority over start and continuous in the same cycle.

Verification
REQ-031 Single sample: WAIT_CYCLES=4, BASE_SEL=0, a data model returning 0x10+selector on each en -> 8 en pulses 6 cycles apart with selectors 0..7; sample_valid at start+49; press_raw=0x10111, temp_raw=0x13141, hum_raw=0x1617.
REQ-032 xlsb masking: byte 2=0xFF, byte 5=0x0F -> press_raw[3:0]=0xF and temp_raw[3:0]=0x0.
REQ-033 Ignored start: start pulsed during WAIT of byte 3 -> exactly 8 en pulses and one sample_valid, then busy=0.
REQ-034 Continuous: continuous=1 held for 2 samples -> after sample_valid, next en in the following cycle with selector 0; after continuous drops mid-second-sample -> second sample_valid occurs, then IDLE.
REQ-035 Reset mid-operation: rst during byte 5 WAIT -> next cycle en=0, busy=0, all raw outputs 0; a fresh start then completes a correct sample.
REQ-036 Offset/wrap: BASE_SEL=12 -> selectors 12,13,14,15,0,1,2,3 in order.
